// File: rtl/conv3x3_featuremap_acc.sv
// 3x3 same-padded multi-channel convolution with bias, leaky ReLU and
// saturation; one output pixel per input pixel, weights loaded at run time.
module conv3x3_featuremap_acc #(
  parameter int NUM_CH     = 32,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int IMG_W      = 104,
  parameter int IMG_H      = 104
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0]  data_in,
  input  logic                          valid_in,
  output logic                          ready_in,
  input  logic                          w_we,
  input  logic [$clog2(NUM_CH*9+1)-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0]         w_data,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          valid_out,
  output logic                          last_out
);
  localparam int DW   = DATA_WIDTH;
  localparam int PXW  = NUM_CH*DW;
  localparam int NT   = NUM_CH*9;
  localparam int AD   = $clog2(NT+1);
  localparam int NB   = 2*IMG_W+3;
  localparam int PW   = 2*DW;
  localparam int AW   = PW+$clog2(NT)+1;
  localparam int LAST = IMG_H*IMG_W+IMG_W;
  localparam int SW   = $clog2(LAST+1);
  localparam int RW   = $clog2(IMG_H+1);
  localparam int CW   = $clog2(IMG_W+1);
  localparam logic signed [AW-1:0] MAXV =
    {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = ~MAXV;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t               state, state_nx;
  logic                 step, prod_en;
  logic [SW-1:0]        step_cnt;
  logic [RW-1:0]        crow, r0;
  logic [CW-1:0]        ccol, c0;
  logic                 v0, v1, v2, l1, l2;
  logic [PXW-1:0]       sbuf [NB];
  logic signed [DW-1:0] wgt [NT];
  logic signed [DW-1:0] bias, bias1;
  logic signed [DW-1:0] tap [NT];
  logic signed [PW-1:0] prod_nx [NT];
  logic signed [PW-1:0] prod [NT];
  logic signed [AW-1:0] sum_nx, acc, lrelu, shv;
  logic [DW-1:0]        sat;
  logic [2:0]           row_ok, col_ok;

  always_comb begin
    state_nx = state;
    ready_in = 1'b0;
    step     = 1'b0;
    unique case (state)
      RUN: begin
        ready_in = 1'b1;
        step     = valid_in;
        if (step && step_cnt == SW'(IMG_H*IMG_W-1))
          state_nx = FLUSH;
      end
      FLUSH: begin
        step = 1'b1;
        if (step_cnt == SW'(LAST))
          state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
  end

  assign prod_en = step && (step_cnt >= SW'(IMG_W+1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      step_cnt <= '0;
      crow     <= '0;
      ccol     <= '0;
      r0       <= '0;
      c0       <= '0;
      v0       <= 1'b0;
    end else begin
      state <= state_nx;
      v0    <= prod_en;
      if (step)
        step_cnt <= (step_cnt == SW'(LAST)) ? '0 : step_cnt + SW'(1);
      if (prod_en) begin
        r0 <= crow;
        c0 <= ccol;
        if (ccol == CW'(IMG_W-1)) begin
          ccol <= '0;
          crow <= (crow == RW'(IMG_H-1)) ? '0 : crow + RW'(1);
        end else begin
          ccol <= ccol + CW'(1);
        end
      end
    end
  end

  // Flush steps shift in zeros; padding masks hide them anyway.
  always_ff @(posedge clk) begin
    if (step) begin
      sbuf[0] <= (state == RUN) ? data_in : '0;
      for (int p = 1; p < NB; p++)
        sbuf[p] <= sbuf[p-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NT; i++)
        wgt[i] <= '0;
      bias <= '0;
    end else if (w_we) begin
      if (w_addr < AD'(NT))
        wgt[w_addr] <= w_data;
      else if (w_addr == AD'(NT))
        bias <= w_data;
    end
  end

  always_comb begin
    row_ok = {r0 != RW'(IMG_H-1), 1'b1, r0 != '0};
    col_ok = {c0 != CW'(IMG_W-1), 1'b1, c0 != '0};
  end

  // Newest pixel sits at sbuf[0]; the centre is IMG_W+1 words back.
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++)
      for (int ky = 0; ky < 3; ky++)
        for (int kx = 0; kx < 3; kx++)
          tap[ch*9+ky*3+kx] = (row_ok[ky] && col_ok[kx]) ?
            signed'(sbuf[(2-ky)*IMG_W+(2-kx)][ch*DW +: DW]) : '0;
  end

  always_comb begin
    for (int i = 0; i < NT; i++)
      prod_nx[i] = tap[i] * wgt[i];
  end

  always_comb begin
    sum_nx = AW'(bias1) <<< FRAC_BITS;
    for (int i = 0; i < NT; i++)
      sum_nx = sum_nx + AW'(prod[i]);
  end

  always_comb begin
    lrelu = acc[AW-1] ? (acc >>> 3) : acc;
    shv   = lrelu >>> FRAC_BITS;
    if (shv > MAXV)
      sat = MAXV[DW-1:0];
    else if (shv < MINV)
      sat = MINV[DW-1:0];
    else
      sat = shv[DW-1:0];
  end

  always_ff @(posedge clk) begin
    prod  <= prod_nx;
    bias1 <= bias;
    acc   <= sum_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      l1        <= 1'b0;
      l2        <= 1'b0;
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      data_out  <= '0;
    end else begin
      v1        <= v0;
      l1        <= v0 && r0 == RW'(IMG_H-1) && c0 == CW'(IMG_W-1);
      v2        <= v1;
      l2        <= l1;
      valid_out <= v2;
      last_out  <= l2;
      if (v2)
        data_out <= sat;
    end
  end
endmodule

// File: tb/tb_conv3x3_featuremap_acc.sv
// Directed bench for conv3x3_featuremap_acc on a 2-channel 4x4 image.
// Outputs are logged with edge stamps and compared to hand-derived values.
module tb_conv3x3_featuremap_acc;
  localparam int NC  = 2;
  localparam int DW  = 16;
  localparam int W   = 4;
  localparam int H   = 4;
  localparam int AWD = $clog2(NC*9+1);

  logic           clk = 1'b0;
  logic           rst;
  logic [NC*DW-1:0] data_in;
  logic           valid_in, ready_in, w_we;
  logic [AWD-1:0] w_addr;
  logic [DW-1:0]  w_data, data_out;
  logic           valid_out, last_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [15:0] od[$];
  bit          ol[$];
  int          ot[$];
  int          ast[$];

  conv3x3_featuremap_acc #(
    .NUM_CH(NC), .DATA_WIDTH(DW), .FRAC_BITS(8),
    .IMG_W(W), .IMG_H(H)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in),
    .valid_in(valid_in), .ready_in(ready_in),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .data_out(data_out), .valid_out(valid_out),
    .last_out(last_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (valid_out === 1'b1) begin
      od.push_back(data_out);
      ol.push_back(last_out);
      ot.push_back(cyc - 1);
    end

  task automatic clear_log();
    od.delete(); ol.delete(); ot.delete();
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    w_we = 1'b1; w_addr = AWD'(a); w_data = d;
    @(negedge clk);
    w_we = 1'b0;
  endtask

  task automatic load(input logic [15:0] w0, input logic [15:0] w1,
                      input bit centre, input logic [15:0] b);
    for (int ch = 0; ch < NC; ch++)
      for (int t = 0; t < 9; t++)
        wr(ch*9+t, (centre && t != 4) ? 16'h0 : (ch == 0 ? w0 : w1));
    wr(NC*9, b);
  endtask

  task automatic run_frame(input logic [15:0] p0, input logic [15:0] p1,
                           input bit ramp, input int gap, input bit hold,
                           output int low);
    int n = 0;
    int bnd = 0;
    low = 0;
    ast.delete();
    while (n < W*H && bnd < 1000) begin
      data_in  = {p1, ramp ? 16'((n+1)*16) : p0};
      valid_in = ($urandom_range(99) >= gap);
      if (valid_in && ready_in) begin
        ast.push_back(cyc);
        n++;
      end
      @(negedge clk);
      bnd++;
    end
    checks++;
    if (n != W*H) begin
      errors++;
      $display("FAIL frame_accepts got %0d want %0d", n, W*H);
    end
    valid_in = hold;
    bnd = 0;
    while (!ready_in && bnd < 50) begin
      low++;
      @(negedge clk);
      bnd++;
    end
  endtask

  task automatic drain(input int n, input string nm);
    int b = 0;
    while (od.size() < n && b < 60) begin
      @(negedge clk);
      b++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (od.size() != n) begin
      errors++;
      $display("FAIL %s_count got %0d want %0d", nm, od.size(), n);
    end
  endtask

  task automatic check_low(input int low, input string nm);
    checks++;
    if (low != W+1) begin
      errors++;
      $display("FAIL %s_ready_low got %0d want %0d", nm, low, W+1);
    end
  endtask

  // mode 0: 3x3 box of ones, 1: constant v, 2: ramp (k+1)*16
  task automatic check_frame(input int base, input int mode,
                             input logic [15:0] v, input string nm);
    logic [15:0] box [16] = '{
      16'h0400, 16'h0600, 16'h0600, 16'h0400,
      16'h0600, 16'h0900, 16'h0900, 16'h0600,
      16'h0600, 16'h0900, 16'h0900, 16'h0600,
      16'h0400, 16'h0600, 16'h0600, 16'h0400};
    logic [15:0] e;
    for (int j = 0; j < 16; j++) begin
      e = (mode == 0) ? box[j] : (mode == 1) ? v : 16'((j+1)*16);
      checks++;
      if (base + j >= od.size()) begin
        errors++;
        $display("FAIL %s_pix%0d got none want %h", nm, j, e);
      end else begin
        if (od[base+j] !== e) begin
          errors++;
          $display("FAIL %s_pix%0d got %h want %h", nm, j, od[base+j], e);
        end
        checks++;
        if (ol[base+j] !== (j == 15)) begin
          errors++;
          $display("FAIL %s_last%0d got %b want %b", nm, j,
                   ol[base+j], (j == 15));
        end
      end
    end
  endtask

  task automatic check_timing(input string nm);
    int trig;
    for (int j = 0; j < 16 && j < ot.size(); j++) begin
      trig = (j + 5 < 16) ? ast[j+5] : ast[15] + (j + 5 - 15);
      checks++;
      if (ot[j] != trig + 3) begin
        errors++;
        $display("FAIL %s_lat%0d got %0d want %0d", nm, j, ot[j], trig+3);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks += 4;
    if (ready_in !== 1'b1) begin
      errors++; $display("FAIL rst_ready got %b want 1", ready_in);
    end
    if (valid_out !== 1'b0) begin
      errors++; $display("FAIL rst_valid got %b want 0", valid_out);
    end
    if (last_out !== 1'b0) begin
      errors++; $display("FAIL rst_last got %b want 0", last_out);
    end
    if (data_out !== 16'h0) begin
      errors++; $display("FAIL rst_data got %h want 0000", data_out);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_box();
    int low;
    load(16'h0100, 16'h0000, 1'b0, 16'h0000);
    clear_log();
    run_frame(16'h0100, 16'h7FFF, 1'b0, 0, 1'b0, low);
    check_low(low, "box");
    drain(16, "box");
    check_frame(0, 0, 16'h0, "box");
    check_timing("box");
  endtask

  task automatic test_leaky();
    int low;
    load(16'h0100, 16'h0000, 1'b1, 16'hFE00);
    wr(NC*9+1, 16'h7F00);
    wr(31, 16'h7F00);
    clear_log();
    run_frame(16'h0100, 16'h1234, 1'b0, 0, 1'b0, low);
    drain(16, "leaky");
    check_frame(0, 1, 16'hFFE0, "leaky");
  endtask

  task automatic test_saturate();
    int low;
    load(16'h7F00, 16'h7F00, 1'b0, 16'h0000);
    clear_log();
    run_frame(16'h7F00, 16'h7F00, 1'b0, 0, 1'b0, low);
    drain(16, "satpos");
    check_frame(0, 1, 16'h7FFF, "satpos");
    clear_log();
    run_frame(16'h8100, 16'h8100, 1'b0, 0, 1'b0, low);
    drain(16, "satneg");
    check_frame(0, 1, 16'h8000, "satneg");
  endtask

  task automatic test_back_to_back();
    int low1, low2;
    load(16'h0100, 16'h0000, 1'b1, 16'h0000);
    clear_log();
    run_frame(16'h0, 16'h5555, 1'b1, 0, 1'b1, low1);
    run_frame(16'h0, 16'h5555, 1'b1, 0, 1'b0, low2);
    check_low(low1, "b2b_f1");
    check_low(low2, "b2b_f2");
    drain(32, "b2b");
    check_frame(0, 2, 16'h0, "b2b_f1");
    check_frame(16, 2, 16'h0, "b2b_f2");
  endtask

  task automatic test_gaps();
    int low;
    clear_log();
    run_frame(16'h0, 16'h2222, 1'b1, 50, 1'b0, low);
    check_low(low, "gaps");
    drain(16, "gaps");
    check_frame(0, 2, 16'h0, "gaps");
    check_timing("gaps");
  endtask

  task automatic test_reset_midframe();
    int low;
    clear_log();
    for (int n = 0; n < 7; n++) begin
      data_in  = {16'h0, 16'((n+1)*16)};
      valid_in = 1'b1;
      @(negedge clk);
    end
    rst = 1'b1;
    valid_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (od.size() != 0) begin
      errors++;
      $display("FAIL midrst_outputs got %0d want 0", od.size());
    end
    run_frame(16'h0, 16'h0, 1'b1, 0, 1'b0, low);
    drain(16, "midrst_zero");
    check_frame(0, 1, 16'h0000, "midrst_zero");
    load(16'h0100, 16'h0000, 1'b1, 16'h0000);
    clear_log();
    run_frame(16'h0, 16'h0, 1'b1, 0, 1'b0, low);
    drain(16, "midrst");
    check_frame(0, 2, 16'h0, "midrst");
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; w_we = 1'b0;
    w_addr = '0; w_data = '0; data_in = '0;
    @(negedge clk);
    test_reset();
    test_box();
    test_leaky();
    test_saturate();
    test_back_to_back();
    test_gaps();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
